gpr_file_mp: RTL and testbench

//  Parametrised multi-port general-purpose register file for the CPU datapath.

---
 rtl/gpr_file_mp.sv | 95 +++++++++
 tb/tb_gpr_file_mp.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/gpr_file_mp.sv
// Multi-port GPR file: NRP combinational reads, two write ports, sticky overflow flag and W1 busy scoreboard.
// Optional feature: define GPR_BYPASS_EN for write-first reads (same-cycle write data forwarded to reads).
module gpr_file_mp #(
    parameter int unsigned DW       = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned NRP      = 2,
    parameter int unsigned FLAG_REG = 30,
    parameter int unsigned FLAG_BIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRP*AW-1:0] rd_addr,
    output logic [NRP*DW-1:0] rd_data,
    output logic [NRP-1:0]    rd_busy,
    output logic              hazard,
    input  logic              we0,
    input  logic [AW-1:0]     wa0,
    input  logic [DW-1:0]     wd0,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic [DW-1:0]     wd1,
    input  logic              ovf_set,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_dst
);

    logic [DW-1:0]    regs_q [DEPTH];
    logic [DW-1:0]    regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Per-register next state: W1 beats W0, flag forced after the write, issue beats W1 clear.
    always_comb begin
        for (int unsigned a = 0; a < DEPTH; a++) begin
            regs_d[a] = regs_q[a];
            busy_d[a] = busy_q[a];
            if (a != 0) begin
                if (we0 && (wa0 == AW'(a))) begin
                    regs_d[a] = wd0;
                end
                if (we1 && (wa1 == AW'(a))) begin
                    regs_d[a] = wd1;
                    busy_d[a] = 1'b0;
                end
                if (ovf_set && (a == FLAG_REG)) begin
                    regs_d[a][FLAG_BIT] = 1'b1;
                end
                if (issue_valid && (issue_dst == AW'(a))) begin
                    busy_d[a] = 1'b1;
                end
            end else begin
                regs_d[a] = '0;
                busy_d[a] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned a = 0; a < DEPTH; a++) begin
                regs_q[a] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Read ports; outputs are held at zero while reset is asserted.
    for (genvar k = 0; k < NRP; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic          in_rng;
        logic [DW-1:0] rdat;
        logic          rbusy;

        assign ra     = rd_addr[k*AW +: AW];
        assign in_rng = 32'(ra) < DEPTH;
`ifdef GPR_BYPASS_EN
        logic wbyp;
        assign wbyp  = we1 && (wa1 == ra);
        assign rdat  = in_rng ? regs_d[ra] : '0;
        assign rbusy = in_rng && busy_q[ra] && !wbyp;
`else
        assign rdat  = in_rng ? regs_q[ra] : '0;
        assign rbusy = in_rng && busy_q[ra];
`endif
        assign rd_data[k*DW +: DW] = rst ? rdat : '0;
        assign rd_busy[k]          = rst & rbusy;
    end

    assign hazard = |rd_busy;

endmodule

// File: tb/tb_gpr_file_mp.sv
// Self-checking bench for gpr_file_mp: table of one-cycle write vectors followed by read checks,
// plus hand-written sequences for async reset and same-cycle read/write behaviour.
module tb_gpr_file_mp;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        hazard;
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        ovf_set;
    logic        issue_valid;
    logic [4:0]  issue_dst;

    int pass_cnt = 0;
    int total    = 0;

    gpr_file_mp dut (
        .clk         (clk),
        .rst         (rst),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .hazard      (hazard),
        .we0         (we0),
        .wa0         (wa0),
        .wd0         (wd0),
        .we1         (we1),
        .wa1         (wa1),
        .wd1         (wd1),
        .ovf_set     (ovf_set),
        .issue_valid (issue_valid),
        .issue_dst   (issue_dst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        ovf;
        logic        iv;
        logic [4:0]  idst;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        ovf_set = 1'b0; issue_valid = 1'b0; issue_dst = '0;
    endtask

    task automatic check_reads(input string name, input logic [31:0] e0, input logic [31:0] e1,
                               input logic [1:0] eb);
        check({name, ".d0"}, rd_data[31:0], e0);
        check({name, ".d1"}, rd_data[63:32], e1);
        check({name, ".busy"}, 32'(rd_busy), 32'(eb));
        check({name, ".haz"}, 32'(hazard), 32'(|eb));
    endtask

    // One write cycle, then writes removed and reads checked between edges.
    task automatic apply(input vec_t v);
        @(negedge clk);
        we0 = v.we0; wa0 = v.wa0; wd0 = v.wd0;
        we1 = v.we1; wa1 = v.wa1; wd1 = v.wd1;
        ovf_set = v.ovf; issue_valid = v.iv; issue_dst = v.idst;
        @(posedge clk);
        #1;
        idle_inputs();
        rd_addr = {v.ra1, v.ra0};
        #1;
        check_reads(v.name, v.e0, v.e1, v.eb);
    endtask

    function automatic vec_t mk(input string name,
                                input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                                input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                                input logic ovf, input logic iv, input logic [4:0] idst,
                                input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] eb);
        vec_t v;
        v.name = name;
        v.we0 = w0; v.wa0 = a0; v.wd0 = d0;
        v.we1 = w1; v.wa1 = a1; v.wd1 = d1;
        v.ovf = ovf; v.iv = iv; v.idst = idst;
        v.ra0 = ra0; v.ra1 = ra1;
        v.e0 = e0; v.e1 = e1; v.eb = eb;
        return v;
    endfunction

    initial begin
        rst = 1'b0;
        idle_inputs();
        rd_addr = {5'd30, 5'd5};

        vecs.push_back(mk("w0_r5",      1, 5,  32'h1234,     0, 0,  0,        0, 0, 0,  5,  0,  32'h1234, 0,        2'b00));
        vecs.push_back(mk("w0_r0",      1, 0,  32'hFFFF_FFFF,0, 0,  0,        0, 0, 0,  0,  5,  0,        32'h1234, 2'b00));
        vecs.push_back(mk("collide7",   1, 7,  32'hAAAA,     1, 7,  32'h5555, 0, 0, 0,  7,  5,  32'h5555, 32'h1234, 2'b00));
        vecs.push_back(mk("flag_wr",    1, 30, 32'h10,       0, 0,  0,        1, 0, 0,  30, 7,  32'h11,   32'h5555, 2'b00));
        vecs.push_back(mk("flag_only",  0, 0,  0,            0, 0,  0,        1, 0, 0,  30, 0,  32'h11,   0,        2'b00));
        vecs.push_back(mk("flag_clr",   1, 30, 32'h20,       0, 0,  0,        0, 0, 0,  30, 0,  32'h20,   0,        2'b00));
        vecs.push_back(mk("flag_coll",  1, 30, 32'h40,       1, 30, 32'h80,   1, 0, 0,  30, 0,  32'h81,   0,        2'b00));
        vecs.push_back(mk("issue9",     0, 0,  0,            0, 0,  0,        0, 1, 9,  9,  0,  0,        0,        2'b01));
        vecs.push_back(mk("set_win9",   0, 0,  0,            1, 9,  32'h99,   0, 1, 9,  9,  0,  32'h99,   0,        2'b01));
        vecs.push_back(mk("clr9",       0, 0,  0,            1, 9,  32'h9A,   0, 0, 0,  9,  0,  32'h9A,   0,        2'b00));
        vecs.push_back(mk("issue12",    0, 0,  0,            0, 0,  0,        0, 1, 12, 0,  12, 0,        0,        2'b10));
        vecs.push_back(mk("w0_keep12",  1, 12, 32'h12,       0, 0,  0,        0, 0, 0,  0,  12, 0,        32'h12,   2'b10));
        vecs.push_back(mk("issue0",     0, 0,  0,            0, 0,  0,        0, 1, 0,  0,  0,  0,        0,        2'b00));
        vecs.push_back(mk("clr12",      0, 0,  0,            1, 12, 32'h1212, 0, 0, 0,  12, 9,  32'h1212, 32'h9A,   2'b00));

        // Reset state
        #3;
        check_reads("rst_init", 0, 0, 2'b00);
        #9;
        rst = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // Same-cycle W1 write to a busy register read on port 1
        apply(mk("issue3", 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 3, 0, 0, 2'b10));
        @(negedge clk);
        we1 = 1'b1; wa1 = 5'd3; wd1 = 32'hCAFE;
        rd_addr = {5'd3, 5'd5};
        #1;
`ifdef GPR_BYPASS_EN
        check_reads("byp_same", 32'h1234, 32'hCAFE, 2'b00);
`else
        check_reads("byp_same", 32'h1234, 0, 2'b10);
`endif
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        check_reads("byp_after", 32'h1234, 32'hCAFE, 2'b00);

        // Asynchronous reset mid-cycle with a busy register outstanding
        apply(mk("issue20", 0, 0, 0, 0, 0, 0, 0, 1, 20, 5, 20, 32'h1234, 0, 2'b10));
        #2;
        rst = 1'b0;
        #1;
        check_reads("async_rst", 0, 0, 2'b00);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rd_addr = {5'd30, 5'd5};
        #1;
        check_reads("post_rst", 0, 0, 2'b00);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
